// File: rtl/branch_history_predictor_pkg.sv
// Shared types for the branch history predictor: the resolution-pulse struct,
// the table-init FSM states and the 2-bit counter encoding.
package branch_history_predictor_pkg;

  typedef struct packed {
    logic        en;
    logic [31:0] pc;
    logic        actual_taken;
  } bp_update_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } bhp_state_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/branch_history_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
  import branch_history_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_predictor.sv
// Bimodal branch predictor: a table of 2-bit counters indexed by PC, swept to
// INIT_CTR after reset or flush, with update bypass into same-cycle lookups.
module branch_history_predictor
  import branch_history_predictor_pkg::*;
#(
  parameter int         NUM_ENTRIES = 64,
  parameter logic [1:0] INIT_CTR    = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  bp_update_t  bp_update,
  input  logic        flush_req,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        lookup_ready,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_disagree
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  bhp_state_e        state_q;
  logic [IDX_W-1:0]  init_idx_q;
  logic              lookup_ready_q;
  logic              pred_valid_q;
  logic              pred_taken_q;
  logic [31:0]       stat_updates_q;
  logic [31:0]       stat_disagree_q;
  logic [1:0]        table_q [NUM_ENTRIES];

  logic [IDX_W-1:0]  upd_idx;
  logic [IDX_W-1:0]  lk_idx;
  logic [1:0]        upd_old;
  logic [1:0]        upd_new;
  logic              upd_apply;
  logic              lk_dir_d;

  assign upd_idx   = bp_update.pc[IDX_W+1:2];
  assign lk_idx    = lookup_pc[IDX_W+1:2];
  assign upd_old   = table_q[upd_idx];
  // A flush in the same cycle drops the update entirely.
  assign upd_apply = (state_q == READY) && bp_update.en && !flush_req;

  sat_counter2 u_sat_counter2 (
    .ctr_i   (upd_old),
    .taken_i (bp_update.actual_taken),
    .ctr_o   (upd_new)
  );

  always_comb begin
    lk_dir_d = table_q[lk_idx][1];
    if (upd_apply && (upd_idx == lk_idx)) lk_dir_d = upd_new[1];
  end

  // Table storage carries no reset; the INIT sweep defines its contents.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      table_q[init_idx_q] <= INIT_CTR;
    end else if (upd_apply) begin
      table_q[upd_idx] <= upd_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= INIT;
      init_idx_q      <= '0;
      lookup_ready_q  <= 1'b0;
      pred_valid_q    <= 1'b0;
      pred_taken_q    <= 1'b0;
      stat_updates_q  <= '0;
      stat_disagree_q <= '0;
    end else begin
      case (state_q)
        INIT: begin
          pred_valid_q <= 1'b0;
          if (flush_req) begin
            init_idx_q <= '0;
          end else if (init_idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
            init_idx_q     <= '0;
            state_q        <= READY;
            lookup_ready_q <= 1'b1;
          end else begin
            init_idx_q <= init_idx_q + IDX_W'(1);
          end
        end
        READY: begin
          if (flush_req) begin
            state_q        <= INIT;
            lookup_ready_q <= 1'b0;
            init_idx_q     <= '0;
          end
          if (upd_apply) begin
            stat_updates_q <= stat_updates_q + 32'd1;
            if (upd_old[1] != bp_update.actual_taken)
              stat_disagree_q <= stat_disagree_q + 32'd1;
          end
          pred_valid_q <= lookup_valid;
          if (lookup_valid) pred_taken_q <= lk_dir_d;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign lookup_ready  = lookup_ready_q;
  assign pred_valid    = pred_valid_q;
  assign pred_taken    = pred_taken_q;
  assign stat_updates  = stat_updates_q;
  assign stat_disagree = stat_disagree_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                            bp_update.pc[31:IDX_W+2], bp_update.pc[1:0]};

endmodule

// File: tb/tb_branch_history_predictor.sv
// Bench for branch_history_predictor: directed scenarios plus random traffic
// compared against an array-of-integers reference predictor.
module tb_branch_history_predictor;
  import branch_history_predictor_pkg::*;

  localparam int N = 64;
  localparam int INIT_VAL = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  bp_update_t  bp_update;
  logic        flush_req;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] stat_updates;
  logic [31:0] stat_disagree;

  branch_history_predictor #(.NUM_ENTRIES(N), .INIT_CTR(2'b01)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bp_update     (bp_update),
    .flush_req     (flush_req),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .lookup_ready  (lookup_ready),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .stat_updates  (stat_updates),
    .stat_disagree (stat_disagree)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference predictor state
  int          m_tbl [N];
  bit          m_ready;
  int          m_init_left;
  bit          m_pv;
  bit          m_pt;
  bit [31:0]   m_upd;
  bit [31:0]   m_dis;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 0;
    m_init_left = N;
    m_pv = 0;
    m_pt = 0;
    m_upd = 0;
    m_dis = 0;
  endtask

  task automatic model_step(input bit lv, input bit [31:0] lpc, input bit en,
                            input bit [31:0] upc, input bit tk, input bit fl);
    int li, ui, old;
    li = int'((lpc >> 2) % N);
    ui = int'((upc >> 2) % N);
    if (m_ready) begin
      if (fl) begin
        m_ready = 0;
        m_init_left = N;
      end else if (en) begin
        old = m_tbl[ui];
        m_upd++;
        if ((old >= 2) != tk) m_dis++;
        if (tk) m_tbl[ui] = (old == 3) ? 3 : old + 1;
        else    m_tbl[ui] = (old == 0) ? 0 : old - 1;
      end
      m_pv = lv;
      if (lv) m_pt = (m_tbl[li] >= 2);
    end else begin
      m_pv = 0;
      if (fl) m_init_left = N;
      else begin
        m_init_left--;
        if (m_init_left == 0) begin
          m_ready = 1;
          for (int i = 0; i < N; i++) m_tbl[i] = INIT_VAL;
        end
      end
    end
  endtask

  task automatic check_all();
    check_eq("lookup_ready", lookup_ready, m_ready);
    check_eq("pred_valid", pred_valid, m_pv);
    check_eq("pred_taken", pred_taken, m_pt);
    check_eq("stat_updates", stat_updates, m_upd);
    check_eq("stat_disagree", stat_disagree, m_dis);
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input bit lv, input bit [31:0] lpc, input bit en,
                       input bit [31:0] upc, input bit tk, input bit fl);
    lookup_valid = lv;
    lookup_pc    = lpc;
    bp_update.en = en;
    bp_update.pc = upc;
    bp_update.actual_taken = tk;
    flush_req    = fl;
    model_step(lv, lpc, en, upc, tk, fl);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    lookup_valid = 0;
    lookup_pc    = '0;
    bp_update    = '0;
    flush_req    = 0;
  endtask

  logic [31:0] saved_upd, saved_dis;
  logic        pt_a;

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    check_eq("rst_pred_taken", pred_taken, 0);
    rst_n = 1'b1;

    // Init sweep: traffic during INIT must be ignored
    repeat (N) cycle(1, $urandom, 1, $urandom, 1, 0);
    check_eq("ready_after_init", lookup_ready, 1);
    cycle(1, 32'h100, 0, 0, 0, 0);
    check_eq("init_pred_nt", pred_taken, 0);

    repeat (3) cycle(0, 0, 1, 32'h100, 1, 0);
    cycle(1, 32'h100, 0, 0, 0, 0);
    check_eq("three_taken_pt", pred_taken, 1);
    check_eq("three_taken_upd", stat_updates, 3);
    check_eq("three_taken_dis", stat_disagree, 1);

    // Saturation at 11, then at 00
    cycle(0, 0, 1, 32'h100, 1, 0);
    cycle(1, 32'h100, 0, 0, 0, 0);
    check_eq("sat_hi_pt", pred_taken, 1);
    repeat (4) cycle(0, 0, 1, 32'h100, 0, 0);
    cycle(0, 0, 1, 32'h100, 1, 0);
    cycle(1, 32'h100, 0, 0, 0, 0);
    check_eq("sat_lo_pt", pred_taken, 0);

    // Same-cycle bypass through the 0x200 alias at counter 01
    cycle(1, 32'h200, 1, 32'h200, 1, 0);
    check_eq("bypass_pt", pred_taken, 1);
    cycle(1, 32'h100, 0, 0, 0, 0);
    pt_a = pred_taken;
    cycle(1, 32'h200, 0, 0, 0, 0);
    check_eq("alias_same", pred_taken, pt_a);

    // Flush with a simultaneous update
    saved_upd = stat_updates;
    saved_dis = stat_disagree;
    cycle(0, 0, 1, 32'h100, 1, 1);
    repeat (N) cycle(1, $urandom, 1, $urandom, $urandom_range(0, 1), 0);
    check_eq("flush_ready", lookup_ready, 1);
    cycle(1, 32'h100, 0, 0, 0, 0);
    check_eq("flush_reinit_pt", pred_taken, 0);
    check_eq("flush_upd_kept", stat_updates, saved_upd);
    check_eq("flush_dis_kept", stat_disagree, saved_dis);

    // Random traffic, confined to a few indices to provoke bypass and aliasing
    for (int c = 0; c < 1500; c++) begin
      cycle($urandom_range(0, 1), $urandom & 32'hFFFF_FF1F,
            $urandom_range(0, 1), $urandom & 32'hFFFF_FF1F,
            $urandom_range(0, 1), $urandom_range(0, 63) == 0);
    end

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N) cycle(1, $urandom, 1, $urandom, 1, 0);
    repeat (100) begin
      cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
            $urandom_range(0, 1), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
